// File: rtl/chip8_display_blitter.sv
// CHIP-8 sprite blitter: XORs one sprite row per draw into a 64x32 framebuffer via read-modify-write.
// Define CHIP8_CLIP_EN to discard pixels past column 63 instead of wrapping them to column 0.
module chip8_display_blitter #(
  parameter int CLEAR_ROWS = 32
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        draw,
  input  logic [5:0]  x,
  input  logic [4:0]  y,
  input  logic [7:0]  sprite_data,
  input  logic [3:0]  draw_row_index,
  input  logic        clear,
  input  logic [4:0]  scan_row,
  output logic [63:0] scan_data,
  output logic        collision,
  output logic        busy
);

  localparam int CW = $clog2(CLEAR_ROWS);

  typedef enum logic [1:0] {S_IDLE, S_READ, S_WRITE, S_CLEAR} state_t;

  state_t      state, state_nxt;
  logic [63:0] fb [32];
  logic [5:0]  x_q;
  logic [7:0]  data_q;
  logic [4:0]  row_q;
  logic [63:0] old_q;
  logic [63:0] mask_q;
  logic [63:0] mask_nxt;
  logic [CW-1:0] clr_cnt;

  assign busy = (state != S_IDLE);

  // NOTE: every always_comb output gets a default first so no path can infer a latch.
  always_comb begin
    state_nxt = state;
    unique case (state)
      S_IDLE: begin
        if (clear)     state_nxt = S_CLEAR;
        else if (draw) state_nxt = S_READ;
      end
      S_READ:  state_nxt = S_WRITE;
      S_WRITE: state_nxt = S_IDLE;
      S_CLEAR: if (clr_cnt == CW'(CLEAR_ROWS - 1)) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Sprite byte starts at column 0 (bit 63) and is shifted right to column x.
  always_comb begin
    logic [63:0] base;
    base = {data_q, 56'b0};
`ifdef CHIP8_CLIP_EN
    mask_nxt = base >> x_q;
`else
    mask_nxt = (base >> x_q) | (base << (7'd64 - {1'b0, x_q}));
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register sees pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state     <= S_IDLE;
      x_q       <= '0;
      data_q    <= '0;
      row_q     <= '0;
      old_q     <= '0;
      mask_q    <= '0;
      clr_cnt   <= '0;
      collision <= 1'b0;
    end else begin
      state     <= state_nxt;
      collision <= (state == S_WRITE) && |(old_q & mask_q);
      if (state == S_IDLE) begin
        x_q    <= x;
        data_q <= sprite_data;
        row_q  <= y + {1'b0, draw_row_index};
      end
      if (state == S_READ) begin
        old_q  <= fb[row_q];
        mask_q <= mask_nxt;
      end
      clr_cnt <= (state == S_CLEAR) ? clr_cnt + 1'b1 : '0;
    end
  end

  // NOTE: the framebuffer is reset as registers because reset must blank the screen immediately.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < 32; i++) fb[i] <= '0;
      scan_data <= '0;
    end else begin
      scan_data <= fb[scan_row];
      if (state == S_WRITE)      fb[row_q]   <= old_q ^ mask_q;
      else if (state == S_CLEAR) fb[clr_cnt] <= '0;
    end
  end

endmodule

// File: tb/tb_chip8_display_blitter.sv
// Directed self-checking bench for chip8_display_blitter; expected rows are hand-computed constants.
module tb_chip8_display_blitter;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        draw;
  logic [5:0]  x;
  logic [4:0]  y;
  logic [7:0]  sprite_data;
  logic [3:0]  draw_row_index;
  logic        clear;
  logic [4:0]  scan_row;
  logic [63:0] scan_data;
  logic        collision;
  logic        busy;

  int n_cmp = 0;
  int n_err = 0;

  chip8_display_blitter dut (
    .clk(clk), .reset_n(reset_n), .draw(draw), .x(x), .y(y),
    .sprite_data(sprite_data), .draw_row_index(draw_row_index), .clear(clear),
    .scan_row(scan_row), .scan_data(scan_data), .collision(collision), .busy(busy)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout required completion");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic read_row(input logic [4:0] r, output logic [63:0] d);
    scan_row = r;
    tick();
    d = scan_data;
  endtask

  // Issue one draw and check busy/collision cycle by cycle through edge N+3.
  task automatic do_draw(input string tag, input logic [5:0] xx, input logic [4:0] yy,
                         input logic [3:0] idx, input logic [7:0] dat, input logic exp_coll);
    x = xx; y = yy; draw_row_index = idx; sprite_data = dat; draw = 1'b1;
    tick();
    draw = 1'b0;
    check({tag, " busy N"}, 64'(busy), 64'd1);
    check({tag, " coll N"}, 64'(collision), 64'd0);
    tick();
    check({tag, " busy N+1"}, 64'(busy), 64'd1);
    check({tag, " coll N+1"}, 64'(collision), 64'd0);
    tick();
    check({tag, " busy N+2"}, 64'(busy), 64'd0);
    check({tag, " coll N+2"}, 64'(collision), 64'(exp_coll));
    tick();
    check({tag, " coll N+3"}, 64'(collision), 64'd0);
  endtask

  initial begin
    logic [63:0] d;
    int cnt;

    reset_n = 1'b0; draw = 1'b0; clear = 1'b0; x = '0; y = '0;
    sprite_data = '0; draw_row_index = '0; scan_row = '0;
    #2;
    check("reset scan_data", scan_data, 64'd0);
    check("reset collision", 64'(collision), 64'd0);
    check("reset busy", 64'(busy), 64'd0);
    tick(); tick();
    reset_n = 1'b1;
    tick();

    // Draw then undraw.
    do_draw("draw1", 6'd0, 5'd0, 4'd0, 8'hFF, 1'b0);
    read_row(5'd0, d); check("draw1 row0", d, 64'hFF00_0000_0000_0000);
    do_draw("undraw", 6'd0, 5'd0, 4'd0, 8'hFF, 1'b1);
    read_row(5'd0, d); check("undraw row0", d, 64'd0);

    // Horizontal wrap.
    do_draw("hwrap", 6'd60, 5'd5, 4'd0, 8'hFF, 1'b0);
    read_row(5'd5, d);
`ifdef CHIP8_CLIP_EN
    check("hwrap row5", d, 64'h0000_0000_0000_000F);
`else
    check("hwrap row5", d, 64'hF000_0000_0000_000F);
`endif

    // Vertical wrap: 31 + 2 wraps to row 1, column 3 is bit 60.
    do_draw("vwrap", 6'd3, 5'd31, 4'd2, 8'h80, 1'b0);
    read_row(5'd1, d);  check("vwrap row1", d, 64'h1000_0000_0000_0000);
    read_row(5'd31, d); check("vwrap row31", d, 64'd0);
    read_row(5'd0, d);  check("vwrap row0", d, 64'd0);

    // Partial collision then disjoint draw.
    do_draw("pc seed", 6'd0, 5'd0, 4'd0, 8'h0F, 1'b0);
    do_draw("pc hit", 6'd0, 5'd0, 4'd0, 8'h18, 1'b1);
    read_row(5'd0, d); check("pc row0", d, 64'h1700_0000_0000_0000);
    do_draw("pc disjoint", 6'd0, 5'd0, 4'd0, 8'h20, 1'b0);
    read_row(5'd0, d); check("disjoint row0", d, 64'h3700_0000_0000_0000);

    // Clear with a draw attempted mid-clear.
    clear = 1'b1;
    tick();
    clear = 1'b0;
    cnt = 0;
    while (busy && cnt < 40) begin
      cnt++;
      if (cnt == 5) begin
        x = 6'd8; y = 5'd20; draw_row_index = 4'd0; sprite_data = 8'hFF; draw = 1'b1;
      end
      tick();
      draw = 1'b0;
    end
    check("clear busy cycles", 64'(cnt), 64'd32);
    check("post-clear busy", 64'(busy), 64'd0);
    read_row(5'd0, d);  check("clear row0", d, 64'd0);
    read_row(5'd1, d);  check("clear row1", d, 64'd0);
    read_row(5'd5, d);  check("clear row5", d, 64'd0);
    read_row(5'd20, d); check("clear dropped draw row20", d, 64'd0);

    // Reset during WRITE.
    do_draw("rst seed", 6'd0, 5'd2, 4'd0, 8'hAA, 1'b0);
    read_row(5'd2, d); check("rst seed row2", d, 64'hAA00_0000_0000_0000);
    x = 6'd0; y = 5'd2; draw_row_index = 4'd0; sprite_data = 8'hFF; draw = 1'b1;
    tick();
    draw = 1'b0;
    tick();
    reset_n = 1'b0;
    #1;
    check("rst write busy", 64'(busy), 64'd0);
    check("rst write coll", 64'(collision), 64'd0);
    check("rst write scan", scan_data, 64'd0);
    reset_n = 1'b1;
    read_row(5'd2, d); check("rst write row2", d, 64'd0);
    check("rst write idle", 64'(busy), 64'd0);

    // Reset during CLEAR at row 10; row 12 is only zeroed by the reset.
    do_draw("rst clr seed", 6'd0, 5'd12, 4'd0, 8'hC3, 1'b0);
    read_row(5'd12, d); check("rst clr seed row12", d, 64'hC300_0000_0000_0000);
    clear = 1'b1;
    tick();
    clear = 1'b0;
    repeat (10) tick();
    check("mid-clear busy", 64'(busy), 64'd1);
    reset_n = 1'b0;
    #1;
    check("rst clr busy", 64'(busy), 64'd0);
    check("rst clr scan", scan_data, 64'd0);
    reset_n = 1'b1;
    read_row(5'd12, d); check("rst clr row12", d, 64'd0);
    check("rst clr idle", 64'(busy), 64'd0);

    // Draw after reset behaves like the first draw.
    do_draw("post-rst draw", 6'd0, 5'd0, 4'd0, 8'hFF, 1'b0);
    read_row(5'd0, d); check("post-rst row0", d, 64'hFF00_0000_0000_0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
